// File: rtl/cpu_ctrl_pkg.sv
// rtl/cpu_ctrl_pkg.sv - shared encodings and default constants for the CPU run controller
//
// Purpose: mode/state encoding seen on the mode output, plus the default
// debounce length, slow-run divider and CPU reset hold length.

package cpu_ctrl_pkg;

  typedef enum logic [1:0] {
    MODE_RST_HOLD = 2'd0,
    MODE_HALT     = 2'd1,
    MODE_RUN      = 2'd2,
    MODE_STEP     = 2'd3
  } run_mode_e;

  localparam int DEF_RUN_DIV    = 67108864;
  localparam int DEF_DEB_CYCLES = 1000000;
  localparam int DEF_RST_HOLD   = 4;

endpackage

// File: rtl/input_debounce.sv
// rtl/input_debounce.sv - 2-flop synchronizer plus stability-counter debouncer
//
// Purpose: conditions one raw asynchronous pin into a clean level and a
// one-cycle falling-edge pulse.
// Ports:
//   clk      in   system clock
//   reset_n  in   synchronous active-low reset
//   raw      in   asynchronous pin
//   level    out  debounced level (reset value RESET_VAL)
//   fall     out  registered one-cycle pulse when level goes 1->0

module input_debounce
  import cpu_ctrl_pkg::*;
#(
  parameter int   DEB_CYCLES = DEF_DEB_CYCLES,
  parameter logic RESET_VAL  = 1'b1
) (
  input  logic clk,
  input  logic reset_n,
  input  logic raw,
  output logic level,
  output logic fall
);

  localparam int             CW       = $clog2(DEB_CYCLES + 1);
  localparam logic [CW-1:0]  CNT_LAST = CW'(DEB_CYCLES - 1);

  logic          sync1;
  logic          sync2;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sync1 <= RESET_VAL;
      sync2 <= RESET_VAL;
      level <= RESET_VAL;
      cnt   <= '0;
      fall  <= 1'b0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      fall  <= 1'b0;
      // The count only survives while the synchronized input keeps
      // disagreeing with the level; any bounce back restarts it.
      if (sync2 != level) begin
        if (cnt == CNT_LAST) begin
          level <= sync2;
          cnt   <= '0;
          fall  <= ~sync2;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end else begin
        cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/cpu_run_ctrl.sv
// rtl/cpu_run_ctrl.sv - run/step/halt clock-enable controller for cpu_pipeline
//
// Purpose: drives cpu_ce pulses (prescaled run, full-rate run, single step)
// and a stretched cpu_reset from the board keys and switches.
// Ports:
//   clk         in   system clock, 50 MHz
//   reset_n     in   synchronous active-low controller reset
//   key_step_n  in   raw STEP pushbutton, active-low
//   key_rst_n   in   raw CPU-reset pushbutton, active-low
//   sw_run      in   raw switch, 1 = run, 0 = halt
//   sw_fast     in   raw switch, 1 = cpu_ce every cycle in RUN
//   halt_req    in   halt request from the CPU, sampled on cpu_ce
//   cpu_ce      out  CPU clock enable, one-cycle pulses
//   cpu_reset   out  active-high CPU reset
//   mode        out  0 RST_HOLD, 1 HALT, 2 RUN, 3 STEP
//   halted      out  sticky CPU-requested halt flag
//   cycle_cnt   out  cpu_ce pulses since the last CPU reset

module cpu_run_ctrl
  import cpu_ctrl_pkg::*;
#(
  parameter int RUN_DIV    = DEF_RUN_DIV,
  parameter int DEB_CYCLES = DEF_DEB_CYCLES,
  parameter int RST_HOLD   = DEF_RST_HOLD
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        key_step_n,
  input  logic        key_rst_n,
  input  logic        sw_run,
  input  logic        sw_fast,
  input  logic        halt_req,
  output logic        cpu_ce,
  output logic        cpu_reset,
  output logic [1:0]  mode,
  output logic        halted,
  output logic [31:0] cycle_cnt
);

  localparam int            PW        = $clog2(RUN_DIV);
  localparam logic [PW-1:0] PRE_LAST  = PW'(RUN_DIV - 1);
  localparam int            HW        = $clog2(RST_HOLD + 1);
  localparam logic [HW-1:0] HOLD_INIT = HW'(RST_HOLD);

  run_mode_e     state;
  logic [PW-1:0] prescaler;
  logic [HW-1:0] hold_cnt;

  logic step_press;
  logic rst_press;
  logic run_lvl;
  logic fast_lvl;
  logic halt_hit;

  input_debounce #(.DEB_CYCLES(DEB_CYCLES), .RESET_VAL(1'b1)) u_deb_step (
    .clk(clk), .reset_n(reset_n), .raw(key_step_n), .level(), .fall(step_press)
  );

  input_debounce #(.DEB_CYCLES(DEB_CYCLES), .RESET_VAL(1'b1)) u_deb_rst (
    .clk(clk), .reset_n(reset_n), .raw(key_rst_n), .level(), .fall(rst_press)
  );

  input_debounce #(.DEB_CYCLES(DEB_CYCLES), .RESET_VAL(1'b0)) u_deb_run (
    .clk(clk), .reset_n(reset_n), .raw(sw_run), .level(run_lvl), .fall()
  );

  input_debounce #(.DEB_CYCLES(DEB_CYCLES), .RESET_VAL(1'b0)) u_deb_fast (
    .clk(clk), .reset_n(reset_n), .raw(sw_fast), .level(fast_lvl), .fall()
  );

  // A halt request only counts on a real CPU cycle, not a reset cycle.
  assign halt_hit = halt_req & cpu_ce & ~cpu_reset;
  assign mode     = state;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state     <= MODE_RST_HOLD;
      hold_cnt  <= HOLD_INIT;
      prescaler <= '0;
      cpu_reset <= 1'b1;
      cpu_ce    <= 1'b0;
      halted    <= 1'b0;
      cycle_cnt <= '0;
    end else begin
      cpu_ce <= 1'b0;

      // Seeing the run switch low re-arms RUN entry; a new halt wins.
      if (!run_lvl) halted <= 1'b0;
      if (halt_hit) halted <= 1'b1;

      if (rst_press) begin
        state     <= MODE_RST_HOLD;
        hold_cnt  <= HOLD_INIT;
        prescaler <= '0;
        cpu_reset <= 1'b1;
        halted    <= 1'b0;
        cycle_cnt <= '0;
      end else begin
        case (state)
          MODE_RST_HOLD: begin
            cycle_cnt <= '0;
            prescaler <= '0;
            // cpu_ce runs with reset asserted so the pipeline flushes.
            if (hold_cnt != '0) begin
              hold_cnt  <= hold_cnt - 1'b1;
              cpu_ce    <= 1'b1;
              cpu_reset <= 1'b1;
            end else begin
              cpu_reset <= 1'b0;
              state     <= run_lvl ? MODE_RUN : MODE_HALT;
            end
          end

          MODE_HALT: begin
            if (step_press) begin
              state     <= MODE_STEP;
              cpu_ce    <= 1'b1;
              cycle_cnt <= cycle_cnt + 32'd1;
            end else if (run_lvl && !halted) begin
              state <= MODE_RUN;
            end
          end

          MODE_STEP: begin
            state <= MODE_HALT;
          end

          MODE_RUN: begin
            if (halt_hit || !run_lvl) begin
              state     <= MODE_HALT;
              prescaler <= '0;
            end else if (fast_lvl) begin
              prescaler <= '0;
              cpu_ce    <= 1'b1;
              cycle_cnt <= cycle_cnt + 32'd1;
            end else if (prescaler == PRE_LAST) begin
              prescaler <= '0;
              cpu_ce    <= 1'b1;
              cycle_cnt <= cycle_cnt + 32'd1;
            end else begin
              prescaler <= prescaler + 1'b1;
            end
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// tb/tb_cpu_run_ctrl.sv - scoreboard bench for cpu_run_ctrl

module tb_cpu_run_ctrl;

  logic        clk;
  logic        reset_n;
  logic        key_step_n;
  logic        key_rst_n;
  logic        sw_run;
  logic        sw_fast;
  logic        halt_req;
  logic        cpu_ce;
  logic        cpu_reset;
  logic [1:0]  mode;
  logic        halted;
  logic [31:0] cycle_cnt;

  typedef struct {
    logic [1:0]  mode;
    logic        rst;
    logic [31:0] cnt;
    logic        halted;
    int          gap;      // cycles since previous pulse, 0 = don't care
  } exp_t;

  exp_t sb[$];
  int   compared   = 0;
  int   mismatched = 0;
  int   cyc        = 0;
  int   last_ce    = 0;
  int   pulse_idx  = 0;

  cpu_run_ctrl #(.RUN_DIV(8), .DEB_CYCLES(4), .RST_HOLD(3)) dut (
    .clk(clk), .reset_n(reset_n), .key_step_n(key_step_n), .key_rst_n(key_rst_n),
    .sw_run(sw_run), .sw_fast(sw_fast), .halt_req(halt_req), .cpu_ce(cpu_ce),
    .cpu_reset(cpu_reset), .mode(mode), .halted(halted), .cycle_cnt(cycle_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic push(input logic [1:0] m, input logic r, input logic [31:0] c,
                      input logic h, input int g);
    exp_t e;
    e.mode = m; e.rst = r; e.cnt = c; e.halted = h; e.gap = g;
    sb.push_back(e);
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  // Returns just after the negedge on which the last expected pulse was popped.
  task automatic drain(input string name, input int budget);
    int n = 0;
    while (sb.size() != 0 && n < budget) begin
      @(negedge clk);
      #1;
      n++;
    end
    compared++;
    if (sb.size() != 0) begin
      mismatched++;
      $display("FAIL %s: %0d expected pulses never seen, required 0 left", name, sb.size());
      sb.delete();
    end
  endtask

  // Monitor: every cpu_ce pulse must match the oldest expected entry.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      cyc++;
      if (reset_n && cpu_ce) begin
        pulse_idx++;
        if (sb.size() == 0) begin
          compared++;
          mismatched++;
          $display("FAIL unexpected_ce: pulse %0d at cycle %0d, mode %0d cnt %0d, required none",
                   pulse_idx, cyc, mode, cycle_cnt);
        end else begin
          e = sb.pop_front();
          chk($sformatf("ce%0d_mode", pulse_idx), 32'(mode), 32'(e.mode));
          chk($sformatf("ce%0d_cpu_reset", pulse_idx), 32'(cpu_reset), 32'(e.rst));
          chk($sformatf("ce%0d_cycle_cnt", pulse_idx), cycle_cnt, e.cnt);
          chk($sformatf("ce%0d_halted", pulse_idx), 32'(halted), 32'(e.halted));
          if (e.gap != 0)
            chk($sformatf("ce%0d_gap", pulse_idx), 32'(cyc - last_ce), 32'(e.gap));
        end
        last_ce = cyc;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0; key_step_n = 1'b1; key_rst_n = 1'b1;
    sw_run = 1'b0; sw_fast = 1'b0; halt_req = 1'b0;
    wait_cyc(3);
    chk("reset_cpu_reset", 32'(cpu_reset), 32'd1);
    chk("reset_cpu_ce", 32'(cpu_ce), 32'd0);
    chk("reset_mode", 32'(mode), 32'd0);
    chk("reset_cycle_cnt", cycle_cnt, 32'd0);
    chk("reset_halted", 32'(halted), 32'd0);

    // Reset release, switch in halt: three hold pulses then HALT.
    push(2'd0, 1'b1, 32'd0, 1'b0, 0);
    push(2'd0, 1'b1, 32'd0, 1'b0, 1);
    push(2'd0, 1'b1, 32'd0, 1'b0, 1);
    reset_n = 1'b1;
    drain("rst_release", 20);
    wait_cyc(5);
    chk("post_rst_mode", 32'(mode), 32'd1);
    chk("post_rst_cpu_reset", 32'(cpu_reset), 32'd0);
    chk("post_rst_cpu_ce", 32'(cpu_ce), 32'd0);
    chk("post_rst_cycle_cnt", cycle_cnt, 32'd0);

    // Single step from HALT, then a short glitch that must be filtered.
    push(2'd3, 1'b0, 32'd1, 1'b0, 0);
    key_step_n = 1'b0;
    wait_cyc(10);
    key_step_n = 1'b1;
    drain("step", 20);
    wait_cyc(10);
    chk("step_mode", 32'(mode), 32'd1);
    chk("step_cycle_cnt", cycle_cnt, 32'd1);
    key_step_n = 1'b0;
    wait_cyc(2);
    key_step_n = 1'b1;
    wait_cyc(12);
    chk("glitch_cycle_cnt", cycle_cnt, 32'd1);

    // Slow run: one pulse every 8 cycles.
    push(2'd2, 1'b0, 32'd2, 1'b0, 0);
    push(2'd2, 1'b0, 32'd3, 1'b0, 8);
    push(2'd2, 1'b0, 32'd4, 1'b0, 8);
    sw_run = 1'b1;
    drain("slow_run", 100);

    // Fast run: switch debounced 7 cycles after the last slow pulse.
    push(2'd2, 1'b0, 32'd5, 1'b0, 7);
    for (int c = 6; c <= 10; c++) push(2'd2, 1'b0, 32'(c), 1'b0, 1);
    sw_fast = 1'b1;
    drain("fast_run", 50);

    // Halt request coincident with the pulse just seen.
    halt_req = 1'b1;
    wait_cyc(1);
    chk("halt_mode", 32'(mode), 32'd1);
    chk("halt_halted", 32'(halted), 32'd1);
    chk("halt_cycle_cnt", cycle_cnt, 32'd10);
    halt_req = 1'b0;
    wait_cyc(20);
    chk("halted_blocks_run", 32'(mode), 32'd1);
    sw_run = 1'b0;
    wait_cyc(12);
    chk("halted_cleared", 32'(halted), 32'd0);

    // Resume fast run, then press CPU reset mid-run.
    push(2'd2, 1'b0, 32'd11, 1'b0, 0);
    sw_run = 1'b1;
    drain("resume", 50);
    for (int c = 12; c <= 17; c++) push(2'd2, 1'b0, 32'(c), 1'b0, 1);
    push(2'd0, 1'b1, 32'd0, 1'b0, 2);
    push(2'd0, 1'b1, 32'd0, 1'b0, 1);
    push(2'd0, 1'b1, 32'd0, 1'b0, 1);
    push(2'd2, 1'b0, 32'd1, 1'b0, 2);
    key_rst_n = 1'b0;
    drain("rst_mid_run", 60);
    halt_req = 1'b1;
    wait_cyc(1);
    chk("rst_run_halt_mode", 32'(mode), 32'd1);
    chk("rst_run_cycle_cnt", cycle_cnt, 32'd1);
    halt_req = 1'b0;
    key_rst_n = 1'b1;

    // Step press and run switch rising in the same HALT cycle.
    sw_run = 1'b0;
    sw_fast = 1'b0;
    wait_cyc(12);
    chk("pre_tie_halted", 32'(halted), 32'd0);
    chk("pre_tie_mode", 32'(mode), 32'd1);
    push(2'd3, 1'b0, 32'd2, 1'b0, 0);
    push(2'd2, 1'b0, 32'd3, 1'b0, 10);
    key_step_n = 1'b0;
    sw_run = 1'b1;
    drain("step_vs_run", 60);
    sw_run = 1'b0;
    key_step_n = 1'b1;
    wait_cyc(20);
    chk("final_mode", 32'(mode), 32'd1);
    chk("final_cycle_cnt", cycle_cnt, 32'd3);
    chk("final_queue_empty", 32'(sb.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
